// File: rtl/mips_mem_pkg.sv
// Shared encodings and default widths for the unified-memory arbiter.
package mips_mem_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Serialises fetch and data accesses onto one fixed-latency single-port word memory,
// with data-side priority and a starvation bound that eventually forces a fetch grant.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int AW         = AW_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int LAT_W    = $clog2(MEM_LAT + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  state_t                state_reg, state_next;
  owner_t                owner_reg;
  logic                  we_reg;
  logic [LAT_W-1:0]      lat_cnt_reg;
  logic [STARVE_W-1:0]   starve_cnt_reg;
  logic                  grant;
  logic                  last_wait;

  assign grant     = if_gnt | dm_gnt;
  assign last_wait = (state_reg == WAIT) && (lat_cnt_reg == LAT_W'(1));

  // Grants are gated by rst_n so nothing is granted while reset is held.
  always_comb begin
    state_next = state_reg;
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    case (state_reg)
      IDLE, RESP: begin
        state_next = IDLE;
        if (rst_n && if_req && (!dm_req || starve_cnt_reg == STARVE_W'(STARVE_MAX))) begin
          if_gnt     = 1'b1;
          state_next = ISSUE;
        end else if (rst_n && dm_req) begin
          dm_gnt     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = WAIT;
      WAIT:    if (last_wait) state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // The mem_* registers double as the latched command; they clear when no grant is taken.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg      <= OWN_IF;
      we_reg         <= 1'b0;
      lat_cnt_reg    <= '0;
      starve_cnt_reg <= '0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      if_rdata       <= '0;
      dm_rdata       <= '0;
    end else begin
      mem_en    <= grant;
      mem_we    <= dm_gnt & dm_we;
      mem_addr  <= if_gnt ? if_addr : (dm_gnt ? dm_addr : '0);
      mem_wdata <= dm_gnt ? dm_wdata : '0;
      if (grant) begin
        owner_reg <= if_gnt ? OWN_IF : OWN_DM;
        we_reg    <= dm_gnt & dm_we;
      end

      if (state_reg == ISSUE)     lat_cnt_reg <= LAT_W'(MEM_LAT);
      else if (state_reg == WAIT) lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);

      if (last_wait) begin
        if (owner_reg == OWN_IF) if_rdata <= mem_rdata;
        else if (!we_reg)        dm_rdata <= mem_rdata;
      end

      if (if_gnt)
        starve_cnt_reg <= '0;
      else if (dm_gnt && if_req && starve_cnt_reg != STARVE_W'(STARVE_MAX))
        starve_cnt_reg <= starve_cnt_reg + STARVE_W'(1);
    end
  end

  assign if_rvalid = (state_reg == RESP) && (owner_reg == OWN_IF);
  assign dm_rvalid = (state_reg == RESP) && (owner_reg == OWN_DM);
  assign busy      = (state_reg == ISSUE) || (state_reg == WAIT);

endmodule
